// File: rtl/spart.sv
// SPART: bus-mapped UART with a programmable 16x baud generator, one TX and one RX channel.
// Registers: 00 data (rx buffer / tx load), 01 status {6'b0, tbr, rda}, 10/11 divisor lo/hi.
module spart #(
  parameter logic [15:0] DB_RESET = 16'h0144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd,
  output logic [2:0] dbg_state
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus handshake: an access is valid in any cycle with iocs=1. Reads (iorw=1) are
  // combinational in that cycle; writes (iorw=0) take effect at the closing clock edge.
  logic wr_data, wr_dlo, wr_dhi, rd_data, rd_stat;
  assign wr_data = iocs & ~iorw & (ioaddr == 2'b00);
  assign wr_dlo  = iocs & ~iorw & (ioaddr == 2'b10);
  assign wr_dhi  = iocs & ~iorw & (ioaddr == 2'b11);
  assign rd_data = iocs &  iorw & (ioaddr == 2'b00);
  assign rd_stat = iocs &  iorw & (ioaddr == 2'b01);

  logic [7:0] rx_buf;
  logic [7:0] bus_out;
  logic       bus_drive;

  always_comb begin
    bus_out   = 8'h00;
    bus_drive = 1'b0;
    if (rd_data) begin
      bus_out   = rx_buf;
      bus_drive = 1'b1;
    end else if (rd_stat) begin
      bus_out   = {6'b0, tbr, rda};
      bus_drive = 1'b1;
    end
  end

  assign databus = bus_drive ? bus_out : 8'hzz;

  // ---------------- baud generator ----------------
  logic [15:0] divisor;
  logic [15:0] baud_cnt;
  logic        baud_en;

  // A divisor write restarts the period, so no enable leaks out of the write cycle.
  assign baud_en = (baud_cnt == 16'd0) && !(wr_dlo || wr_dhi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor  <= DB_RESET;
      baud_cnt <= DB_RESET;
    end else if (wr_dlo) begin
      divisor  <= {divisor[15:8], databus};
      baud_cnt <= {divisor[15:8], databus};
    end else if (wr_dhi) begin
      divisor  <= {databus, divisor[7:0]};
      baud_cnt <= {databus, divisor[7:0]};
    end else if (baud_cnt == 16'd0) begin
      baud_cnt <= divisor;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t  tx_state, tx_state_n;
  logic [9:0] tx_shift, tx_shift_n;
  logic [3:0] tx_tick, tx_tick_n;
  logic [3:0] tx_bit, tx_bit_n;
  logic       tbr_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= 10'h3ff;
      tx_tick  <= 4'd0;
      tx_bit   <= 4'd0;
      tbr      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_tick  <= tx_tick_n;
      tx_bit   <= tx_bit_n;
      tbr      <= tbr_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_tick_n  = tx_tick;
    tx_bit_n   = tx_bit;
    tbr_n      = tbr;
    case (tx_state)
      TX_IDLE: begin
        if (wr_data) begin
          tx_shift_n = {1'b1, databus, 1'b0};
          tx_tick_n  = 4'd0;
          tx_bit_n   = 4'd0;
          tbr_n      = 1'b0;
          tx_state_n = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (baud_en) begin
          tx_tick_n = tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            tx_shift_n = {1'b1, tx_shift[9:1]};
            tx_bit_n   = tx_bit + 4'd1;
            if (tx_bit == 4'd9) begin
              tx_state_n = TX_IDLE;
              tbr_n      = 1'b1;
            end
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign txd = (tx_state == TX_SHIFT) ? tx_shift[0] : 1'b1;

  // ---------------- receiver ----------------
  logic rx_s1, rx_s2, rx_s3;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  rx_state_t  rx_state, rx_state_n;
  logic [3:0] rx_tick, rx_tick_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic [7:0] rx_buf_n;
  logic       rda_n;
  logic       buf_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_tick  <= 4'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_buf   <= 8'h00;
      rda      <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_tick  <= rx_tick_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_buf   <= rx_buf_n;
      rda      <= rda_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_tick_n  = rx_tick;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    buf_load   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_tick_n  = 4'd0;
        end
      end
      RX_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (baud_en) begin
          rx_tick_n = rx_tick + 4'd1;
          if (rx_tick == 4'd7) begin
            rx_tick_n = 4'd0;
            if (!rx_s2) begin
              rx_state_n = RX_DATA;
              rx_bit_n   = 3'd0;
            end else begin
              rx_state_n = RX_IDLE;
            end
          end
        end
      end
      RX_DATA: begin
        if (baud_en) begin
          rx_tick_n = rx_tick + 4'd1;
          if (rx_tick == 4'd15) begin
            rx_shift_n = {rx_s2, rx_shift[7:1]};
            rx_bit_n   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (baud_en) begin
          rx_tick_n = rx_tick + 4'd1;
          if (rx_tick == 4'd15) begin
            rx_state_n = RX_IDLE;
            buf_load   = rx_s2;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // A byte landing in the same cycle as a data read keeps rda set.
  always_comb begin
    rx_buf_n = rx_buf;
    rda_n    = rda;
    if (buf_load) begin
      rx_buf_n = rx_shift;
      rda_n    = 1'b1;
    end else if (rd_data) begin
      rda_n = 1'b0;
    end
  end

  assign dbg_state = {tx_state, rx_state};

endmodule

// File: doc/spart.md
SPART -- requirements
Module: spart

Interface
REQ-001 SHALL have parameter DB_RESET, default 16'h0144, meaning the baud divisor loaded at reset (9600 baud at 50 MHz, 16x oversampling).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port iocs  input  1  chip select; a bus access is valid only while high.
REQ-005 SHALL have port iorw  input  1  1 = read from SPART, 0 = write to SPART.
REQ-006 SHALL have port ioaddr  input  2  register select: 00 data, 01 status, 10 divisor low, 11 divisor high.
REQ-007 SHALL have port databus  inout  8  shared bidirectional data bus.
REQ-008 SHALL have port rda  output  1  receive data available.
REQ-009 SHALL have port tbr  output  1  transmit buffer ready.
REQ-010 SHALL have port txd  output  1  serial transmit line, idle high.
REQ-011 SHALL have port rxd  input  1  serial receive line, idle high, asynchronous to clk.

Function
REQ-012 SHALL drive databus only when iocs=1, iorw=1 and ioaddr is 00 or 01; otherwise databus SHALL be 8'hZZ.
REQ-013 SHALL return the receive buffer on a read of 00 and {6'b0, tbr, rda} on a read of 01, combinationally in the same cycle.
REQ-014 SHALL load divisor bits [7:0] on a write of 10 and bits [15:8] on a write of 11, at the clock edge where iocs=1 and iorw=0.
REQ-015 SHALL ignore writes to 01 and reads of 10 or 11, with databus left at Z.
REQ-016 Baud generator SHALL be a 16-bit down counter that reloads the divisor and pulses a one-cycle enable when it reaches 0; the enable period is therefore divisor+1 clocks.
REQ-017 Any divisor write SHALL reload the counter on the next edge without issuing an enable.
REQ-018 TX SHALL use two states, IDLE and SHIFT.
REQ-019 A write of 00 while tbr=1 SHALL load the frame {1'b1, data, 1'b0}, drop tbr on the next edge and enter SHIFT.
REQ-020 A write of 00 while tbr=0 SHALL be ignored.
REQ-021 In SHIFT, txd SHALL present the start bit, data[0]..data[7] (LSB first), then the stop bit, each held for 16 enables.
REQ-022 After the 10th bit completes, TX SHALL return to IDLE, set tbr=1 and hold txd=1.
REQ-023 rxd SHALL pass through a two-flop synchronizer before any use.
REQ-024 RX SHALL use the states IDLE, START, DATA and STOP.
REQ-025 A synchronized falling edge in IDLE SHALL enter START; if rxd is still 0 after 8 enables, RX SHALL enter DATA, otherwise return to IDLE (glitch reject).
REQ-026 In DATA, RX SHALL sample 8 bits LSB first at 16-enable spacing, then sample the stop bit in STOP 16 enables later.
REQ-027 On a stop bit of 1, RX SHALL write the byte to the receive buffer and set rda=1 on the same edge.
REQ-028 On a stop bit of 0 (framing error), RX SHALL discard the byte and leave the buffer and rda unchanged.
REQ-029 A read of 00 SHALL clear rda on the next edge.
REQ-030 If a buffer load and a read of 00 occur in the same cycle, the load SHALL win and rda SHALL stay 1.
REQ-031 On overrun (a new byte while rda=1), the new byte SHALL overwrite the buffer and rda SHALL stay 1.
REQ-032 TX and RX SHALL operate concurrently and independently.

Reset
REQ-033 While rst=0, all of the following SHALL hold immediately: divisor=DB_RESET, counter=DB_RESET, TX and RX in IDLE, txd=1, tbr=1, rda=0, receive buffer=8'h00, databus=Z.
REQ-034 Asserting rst mid-frame SHALL abort TX and RX at once, with no partial byte delivered.

Verification
REQ-035 Reset, then read 01 -> databus=8'h02, txd=1.
REQ-036 Write divisor 10=8'h03, 11=8'h00, then write 00=8'hDE -> tbr=0 next cycle; txd shows 0,0,1,1,1,1,0,1,1,1 with each bit lasting 64 clocks; tbr=1 after 640 clocks.
REQ-037 Loop txd to rxd and send 8'hAD -> rda=1, read 00 returns 8'hAD, rda=0 one cycle after the read.
REQ-038 Drive a 16-clock low glitch on rxd (divisor 3) -> RX returns to IDLE, rda stays 0.
REQ-039 Send frame 8'hF0 with stop=0 -> rda stays 0 and the buffer keeps its previous value; then send 8'h0D twice without reading -> rda=1 and read 00 returns 8'h0D.
REQ-040 Assert rst halfway through a transmit -> txd=1 and tbr=1 immediately; a later write of 00=8'h55 transmits a correct frame.
